// File: rtl/axi_rd_arb_pkg.sv
// Shared types and defaults for the two-master / two-slave AXI read arbiter.
package axi_rd_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int LEN_W_DEF  = 4;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_ADDR = 1'b1
   } arb_state_t;

   typedef logic mst_id_t;
   typedef logic slv_id_t;

endpackage

// File: rtl/axi_rd_addr_decode.sv
// Combinational address-window decode for one master; slave 0 wins on overlapping windows.
module axi_rd_addr_decode
   import axi_rd_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] s0_lo,
   input  logic [ADDR_W-1:0] s0_hi,
   input  logic [ADDR_W-1:0] s1_lo,
   input  logic [ADDR_W-1:0] s1_hi,
   output logic              hit_s0,
   output logic              hit_s1,
   output logic              miss
);

   logic in_s0;
   logic in_s1;

   assign in_s0  = (addr >= s0_lo) && (addr <= s0_hi);
   assign in_s1  = (addr >= s1_lo) && (addr <= s1_hi);
   assign hit_s0 = in_s0;
   assign hit_s1 = ~in_s0 & in_s1;
   assign miss   = ~in_s0 & ~in_s1;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Sequencing controller for the 2x2 AXI read interconnect: AR arbitration plus per-slave burst tracking.
// Define AXI_RD_ARB_RR_EN for round-robin tie-breaking; otherwise M0 wins every tie.
module axi_rd_arbiter
   import axi_rd_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              G_clk,
   input  logic              G_reset,
   input  logic              M0_ARVALID,
   input  logic              M1_ARVALID,
   input  logic [ADDR_W-1:0] M0_ARADDR,
   input  logic [ADDR_W-1:0] M1_ARADDR,
   input  logic [LEN_W-1:0]  M0_ARLEN,
   input  logic [LEN_W-1:0]  M1_ARLEN,
   input  logic              S0_ARREADY,
   input  logic              S1_ARREADY,
   input  logic              S0_RVALID,
   input  logic              S1_RVALID,
   input  logic              S0_RLAST,
   input  logic              S1_RLAST,
   input  logic              M0_RREADY,
   input  logic              M1_RREADY,
   input  logic [ADDR_W-1:0] slave0_addr1,
   input  logic [ADDR_W-1:0] slave0_addr2,
   input  logic [ADDR_W-1:0] slave1_addr1,
   input  logic [ADDR_W-1:0] slave1_addr2,
   output logic              select_master_address,
   output logic              select_slave_address,
   output logic              addr_gate,
   output logic              select_data_M0,
   output logic              select_data_M1,
   output logic              data_en_M0,
   output logic              data_en_M1,
   output logic              rready_src_S0,
   output logic              rready_src_S1,
   output logic              rready_en_S0,
   output logic              rready_en_S1,
   output logic              addr_miss,
   output logic              len_err
);

   logic [1:0]       arvalid, arready_s, rvalid_s, rlast_s, rready_m;
   logic [1:0]       hit_s0, hit_s1, miss, tgt, elig, beat, bad_len;
   logic [LEN_W-1:0] arlen_m [2];

   arb_state_t       state;
   mst_id_t          sel_m, win;
   slv_id_t          sel_s;
   logic [1:0]       m_busy, s_busy, owner, sel_data;
   logic [LEN_W-1:0] arlen_q;
   logic [LEN_W-1:0] len_q [2];
   logic [LEN_W:0]   cnt_q [2];
   logic             hs;

   assign arvalid    = {M1_ARVALID, M0_ARVALID};
   assign arready_s  = {S1_ARREADY, S0_ARREADY};
   assign rvalid_s   = {S1_RVALID, S0_RVALID};
   assign rlast_s    = {S1_RLAST, S0_RLAST};
   assign rready_m   = {M1_RREADY, M0_RREADY};
   assign arlen_m[0] = M0_ARLEN;
   assign arlen_m[1] = M1_ARLEN;

   axi_rd_addr_decode #(.ADDR_W(ADDR_W)) u_dec_m0 (
      .addr(M0_ARADDR), .s0_lo(slave0_addr1), .s0_hi(slave0_addr2),
      .s1_lo(slave1_addr1), .s1_hi(slave1_addr2),
      .hit_s0(hit_s0[0]), .hit_s1(hit_s1[0]), .miss(miss[0])
   );

   axi_rd_addr_decode #(.ADDR_W(ADDR_W)) u_dec_m1 (
      .addr(M1_ARADDR), .s0_lo(slave0_addr1), .s0_hi(slave0_addr2),
      .s1_lo(slave1_addr1), .s1_hi(slave1_addr2),
      .hit_s0(hit_s0[1]), .hit_s1(hit_s1[1]), .miss(miss[1])
   );

   // Target slave index is simply "hit S1"; misses are filtered by elig.
   assign tgt     = hit_s1;
   assign elig[0] = arvalid[0] & ~miss[0] & ~m_busy[0] & ~s_busy[tgt[0]];
   assign elig[1] = arvalid[1] & ~miss[1] & ~m_busy[1] & ~s_busy[tgt[1]];
   assign hs      = (state == ARB_ADDR) & arvalid[sel_m] & arready_s[sel_s];

`ifdef AXI_RD_ARB_RR_EN
   logic rr_ptr;

   assign win = (elig == 2'b11) ? rr_ptr : elig[1];

   always_ff @(posedge G_clk or negedge G_reset) begin
      if (!G_reset)
         rr_ptr <= 1'b0;
      else if (hs)
         rr_ptr <= ~rr_ptr;
   end
`else
   assign win = ~elig[0];
`endif

   always_comb begin
      beat    = '0;
      bad_len = '0;
      for (int s = 0; s < 2; s++) begin
         beat[s]    = s_busy[s] & rvalid_s[s] & rready_m[owner[s]];
         bad_len[s] = rlast_s[s] ? (cnt_q[s] != {1'b0, len_q[s]})
                                 : (cnt_q[s] == {1'b0, len_q[s]});
      end
   end

   always_ff @(posedge G_clk or negedge G_reset) begin
      if (!G_reset) begin
         state    <= ARB_IDLE;
         sel_m    <= 1'b0;
         sel_s    <= 1'b0;
         m_busy   <= '0;
         s_busy   <= '0;
         owner    <= '0;
         sel_data <= '0;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else begin
         // Completion frees first; a handshake never targets a busy slave or master.
         for (int s = 0; s < 2; s++) begin
            if (beat[s]) begin
               cnt_q[s] <= cnt_q[s] + 1'b1;
               if (rlast_s[s]) begin
                  s_busy[s]        <= 1'b0;
                  m_busy[owner[s]] <= 1'b0;
               end
            end
         end
         case (state)
            ARB_IDLE: begin
               if (|elig) begin
                  sel_m <= win;
                  sel_s <= tgt[win];
                  state <= ARB_ADDR;
               end
            end
            ARB_ADDR: begin
               if (hs) begin
                  m_busy[sel_m]   <= 1'b1;
                  s_busy[sel_s]   <= 1'b1;
                  owner[sel_s]    <= sel_m;
                  sel_data[sel_m] <= sel_s;
                  cnt_q[sel_s]    <= '0;
                  state           <= ARB_IDLE;
               end
            end
         endcase
      end
   end

   // Burst length is payload, not control: no reset needed.
   always_ff @(posedge G_clk) begin
      if (state == ARB_IDLE && |elig)
         arlen_q <= arlen_m[win];
      if (hs)
         len_q[sel_s] <= arlen_q;
   end

   assign select_master_address = sel_m;
   assign select_slave_address  = sel_s;
   assign addr_gate             = (state == ARB_ADDR);
   assign select_data_M0        = sel_data[0];
   assign select_data_M1        = sel_data[1];
   assign data_en_M0            = m_busy[0];
   assign data_en_M1            = m_busy[1];
   assign rready_src_S0         = owner[0];
   assign rready_src_S1         = owner[1];
   assign rready_en_S0          = s_busy[0];
   assign rready_en_S1          = s_busy[1];
   assign addr_miss             = G_reset & |(arvalid & miss);
   assign len_err               = |(beat & bad_len);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter; tie expectations follow AXI_RD_ARB_RR_EN when defined.
module tb_axi_rd_arbiter;

   localparam int ADDR_W = 32;
   localparam int LEN_W  = 4;

   logic              G_clk = 1'b0;
   logic              G_reset;
   logic              M0_ARVALID, M1_ARVALID;
   logic [ADDR_W-1:0] M0_ARADDR, M1_ARADDR;
   logic [LEN_W-1:0]  M0_ARLEN, M1_ARLEN;
   logic              S0_ARREADY, S1_ARREADY;
   logic              S0_RVALID, S1_RVALID, S0_RLAST, S1_RLAST;
   logic              M0_RREADY, M1_RREADY;
   logic [ADDR_W-1:0] slave0_addr1, slave0_addr2, slave1_addr1, slave1_addr2;
   logic              select_master_address, select_slave_address, addr_gate;
   logic              select_data_M0, select_data_M1, data_en_M0, data_en_M1;
   logic              rready_src_S0, rready_src_S1, rready_en_S0, rready_en_S1;
   logic              addr_miss, len_err;

   int   npass = 0;
   int   ntot  = 0;
   logic ptr   = 1'b0;
   logic w;

   axi_rd_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .G_clk(G_clk), .G_reset(G_reset),
      .M0_ARVALID(M0_ARVALID), .M1_ARVALID(M1_ARVALID),
      .M0_ARADDR(M0_ARADDR), .M1_ARADDR(M1_ARADDR),
      .M0_ARLEN(M0_ARLEN), .M1_ARLEN(M1_ARLEN),
      .S0_ARREADY(S0_ARREADY), .S1_ARREADY(S1_ARREADY),
      .S0_RVALID(S0_RVALID), .S1_RVALID(S1_RVALID),
      .S0_RLAST(S0_RLAST), .S1_RLAST(S1_RLAST),
      .M0_RREADY(M0_RREADY), .M1_RREADY(M1_RREADY),
      .slave0_addr1(slave0_addr1), .slave0_addr2(slave0_addr2),
      .slave1_addr1(slave1_addr1), .slave1_addr2(slave1_addr2),
      .select_master_address(select_master_address),
      .select_slave_address(select_slave_address),
      .addr_gate(addr_gate),
      .select_data_M0(select_data_M0), .select_data_M1(select_data_M1),
      .data_en_M0(data_en_M0), .data_en_M1(data_en_M1),
      .rready_src_S0(rready_src_S0), .rready_src_S1(rready_src_S1),
      .rready_en_S0(rready_en_S0), .rready_en_S1(rready_en_S1),
      .addr_miss(addr_miss), .len_err(len_err)
   );

   always #5 G_clk = ~G_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(negedge G_clk);
   endtask

   // Expected winner when both masters are eligible.
   function automatic logic tie_win();
`ifdef AXI_RD_ARB_RR_EN
      return ptr;
`else
      return 1'b0;
`endif
   endfunction

   initial begin
      G_reset = 1'b0;
      M0_ARVALID = 0; M1_ARVALID = 1; M0_ARADDR = '0; M1_ARADDR = 32'hFFFF_0000;
      M0_ARLEN = '0; M1_ARLEN = '0; S0_ARREADY = 0; S1_ARREADY = 0;
      S0_RVALID = 0; S1_RVALID = 0; S0_RLAST = 0; S1_RLAST = 0;
      M0_RREADY = 0; M1_RREADY = 0;
      slave0_addr1 = 32'h0000_0000; slave0_addr2 = 32'h0000_00FF;
      slave1_addr1 = 32'h0000_0100; slave1_addr2 = 32'h0000_01FF;

      // Reset state
      repeat (2) cyc();
      #1;
      chk("rst_gate", addr_gate, 0);
      chk("rst_miss", addr_miss, 0);
      chk("rst_den0", data_en_M0, 0);
      chk("rst_ren1", rready_en_S1, 0);
      chk("rst_selm", select_master_address, 0);
      cyc();
      G_reset = 1'b1; M1_ARVALID = 0;

      // Single request M0 -> S0, 4 beats
      cyc();
      M0_ARVALID = 1; M0_ARADDR = 32'h10; M0_ARLEN = 4'd3;
      #1 chk("t1_pre_gate", addr_gate, 0);
      cyc();
      #1;
      chk("t1_gate", addr_gate, 1);
      chk("t1_selm", select_master_address, 0);
      chk("t1_sels", select_slave_address, 0);
      S0_ARREADY = 1;
      cyc();
      M0_ARVALID = 0; S0_ARREADY = 0; ptr = ~ptr;
      #1;
      chk("t1_gate_off", addr_gate, 0);
      chk("t1_den0", data_en_M0, 1);
      chk("t1_den1", data_en_M1, 0);
      chk("t1_seld0", select_data_M0, 0);
      chk("t1_ren0", rready_en_S0, 1);
      chk("t1_rsrc0", rready_src_S0, 0);
      chk("t1_ren1", rready_en_S1, 0);
      M0_RREADY = 1;
      for (int b = 0; b < 4; b++) begin
         S0_RVALID = 1; S0_RLAST = (b == 3);
         #1;
         chk("t1_lenerr", len_err, 0);
         chk("t1_busy", data_en_M0, 1);
         cyc();
      end
      S0_RVALID = 0; S0_RLAST = 0;
      #1;
      chk("t1_free_den0", data_en_M0, 0);
      chk("t1_free_ren0", rready_en_S0, 0);

      // Concurrent M0 -> S0 and M1 -> S1
      M0_ARVALID = 1; M0_ARADDR = 32'h20; M0_ARLEN = 4'd1;
      M1_ARVALID = 1; M1_ARADDR = 32'h180; M1_ARLEN = 4'd1;
      S0_ARREADY = 1; S1_ARREADY = 1;
      w = tie_win();
      cyc();
      #1;
      chk("t2_gate_a", addr_gate, 1);
      chk("t2_selm_a", select_master_address, w);
      chk("t2_sels_a", select_slave_address, w);
      cyc();
      if (w) M1_ARVALID = 0; else M0_ARVALID = 0;
      ptr = ~ptr;
      #1;
      chk("t2_den0_a", data_en_M0, !w);
      chk("t2_den1_a", data_en_M1, w);
      cyc();
      #1;
      chk("t2_gate_b", addr_gate, 1);
      chk("t2_selm_b", select_master_address, !w);
      chk("t2_sels_b", select_slave_address, !w);
      cyc();
      M0_ARVALID = 0; M1_ARVALID = 0; ptr = ~ptr;
      #1;
      chk("t2_gate_off", addr_gate, 0);
      chk("t2_den0", data_en_M0, 1);
      chk("t2_den1", data_en_M1, 1);
      chk("t2_seld0", select_data_M0, 0);
      chk("t2_seld1", select_data_M1, 1);
      chk("t2_rsrc0", rready_src_S0, 0);
      chk("t2_rsrc1", rready_src_S1, 1);
      chk("t2_ren0", rready_en_S0, 1);
      chk("t2_ren1", rready_en_S1, 1);
      M1_RREADY = 1;
      for (int b = 0; b < 2; b++) begin
         S0_RVALID = 1; S1_RVALID = 1; S0_RLAST = (b == 1); S1_RLAST = (b == 1);
         #1 chk("t2_lenerr", len_err, 0);
         cyc();
      end
      S0_RVALID = 0; S1_RVALID = 0; S0_RLAST = 0; S1_RLAST = 0;
      #1;
      chk("t2_free_den0", data_en_M0, 0);
      chk("t2_free_den1", data_en_M1, 0);
      chk("t2_free_ren1", rready_en_S1, 0);

      // Contention: both masters to S1, single-beat bursts
      M0_ARVALID = 1; M0_ARADDR = 32'h100; M0_ARLEN = 4'd0;
      M1_ARVALID = 1; M1_ARADDR = 32'h1F0; M1_ARLEN = 4'd0;
      S0_ARREADY = 0; S1_ARREADY = 1;
      for (int r = 0; r < 3; r++) begin
         w = tie_win();
         cyc();
         #1;
         chk("t3_gate", addr_gate, 1);
         chk("t3_winner", select_master_address, w);
         chk("t3_sels", select_slave_address, 1);
         cyc();
         ptr = ~ptr;
         S1_RVALID = 1; S1_RLAST = 1;
         #1;
         chk("t3_den0", data_en_M0, !w);
         chk("t3_den1", data_en_M1, w);
         chk("t3_rsrc1", rready_src_S1, w);
         chk("t3_lenerr", len_err, 0);
         cyc();
         S1_RVALID = 0; S1_RLAST = 0;
         #1;
         chk("t3_regrant_gap", addr_gate, 0);
         chk("t3_free", data_en_M0 | data_en_M1, 0);
      end
      M0_ARVALID = 0; M1_ARVALID = 0;

      // Unmapped M1 request alongside normal M0 traffic
      M1_ARVALID = 1; M1_ARADDR = 32'hFFFF_0000;
      M0_ARVALID = 1; M0_ARADDR = 32'h30; M0_ARLEN = 4'd0; S0_ARREADY = 1;
      #1;
      chk("t4_miss", addr_miss, 1);
      chk("t4_gate_pre", addr_gate, 0);
      cyc();
      #1;
      chk("t4_gate", addr_gate, 1);
      chk("t4_selm", select_master_address, 0);
      chk("t4_miss_b", addr_miss, 1);
      cyc();
      ptr = ~ptr;
      M0_ARVALID = 0; S0_RVALID = 1; S0_RLAST = 1;
      #1;
      chk("t4_miss_c", addr_miss, 1);
      chk("t4_gate_off", addr_gate, 0);
      chk("t4_den1", data_en_M1, 0);
      chk("t4_den0", data_en_M0, 1);
      chk("t4_lenerr", len_err, 0);
      cyc();
      S0_RVALID = 0; S0_RLAST = 0;
      #1 chk("t4_free", data_en_M0, 0);
      cyc();
      #1;
      chk("t4_never_gate", addr_gate, 0);
      chk("t4_miss_d", addr_miss, 1);
      M1_ARVALID = 0;
      #1 chk("t4_miss_clr", addr_miss, 0);

      // Length error: early RLAST on M0 -> S1
      M0_ARVALID = 1; M0_ARADDR = 32'h140; M0_ARLEN = 4'd3;
      cyc();
      #1;
      chk("t5_gate", addr_gate, 1);
      chk("t5_sels", select_slave_address, 1);
      cyc();
      ptr = ~ptr;
      M0_ARVALID = 0;
      #1;
      chk("t5_seld0", select_data_M0, 1);
      chk("t5_rsrc1", rready_src_S1, 0);
      chk("t5_den0", data_en_M0, 1);
      S1_RVALID = 1; S1_RLAST = 0;
      #1 chk("t5_beat0", len_err, 0);
      cyc();
      S1_RLAST = 1;
      #1 chk("t5_early_last", len_err, 1);
      cyc();
      S1_RVALID = 0; S1_RLAST = 0;
      #1;
      chk("t5_err_clr", len_err, 0);
      chk("t5_free", data_en_M0, 0);
      chk("t5_ren1", rready_en_S1, 0);
      chk("t5_seld0_hold", select_data_M0, 1);

      // Length error: missing RLAST on M1 -> S0, ARLEN=0
      M1_ARVALID = 1; M1_ARADDR = 32'h40; M1_ARLEN = 4'd0;
      cyc();
      #1;
      chk("t5b_selm", select_master_address, 1);
      chk("t5b_sels", select_slave_address, 0);
      cyc();
      ptr = ~ptr;
      M1_ARVALID = 0; S0_RVALID = 1; S0_RLAST = 0;
      #1;
      chk("t5b_no_last", len_err, 1);
      chk("t5b_seld1", select_data_M1, 0);
      cyc();
      S0_RLAST = 1;
      #1;
      chk("t5b_late_last", len_err, 1);
      chk("t5b_busy", data_en_M1, 1);
      cyc();
      S0_RVALID = 0; S0_RLAST = 0;
      #1 chk("t5b_free", data_en_M1, 0);

      // Reset mid-burst on M1 -> S1
      M1_ARVALID = 1; M1_ARADDR = 32'h150; M1_ARLEN = 4'd3;
      cyc();
      cyc();
      M1_ARVALID = 0; S1_RVALID = 1; S1_RLAST = 0;
      #1;
      chk("t6_seld1", select_data_M1, 1);
      chk("t6_rsrc1", rready_src_S1, 1);
      chk("t6_den1", data_en_M1, 1);
      cyc();
      G_reset = 1'b0; ptr = 1'b0;
      #1;
      chk("t6_rst_den1", data_en_M1, 0);
      chk("t6_rst_ren1", rready_en_S1, 0);
      chk("t6_rst_rsrc1", rready_src_S1, 0);
      chk("t6_rst_seld1", select_data_M1, 0);
      chk("t6_rst_seld0", select_data_M0, 0);
      chk("t6_rst_selm", select_master_address, 0);
      chk("t6_rst_sels", select_slave_address, 0);
      chk("t6_rst_lenerr", len_err, 0);
      cyc();
      G_reset = 1'b1; S1_RVALID = 0;
      M0_ARVALID = 1; M0_ARADDR = 32'h10; M0_ARLEN = 4'd0;
      cyc();
      #1;
      chk("t6_regrant", addr_gate, 1);
      chk("t6_selm", select_master_address, 0);
      cyc();
      M0_ARVALID = 0; S0_RVALID = 1; S0_RLAST = 1;
      #1;
      chk("t6_den0", data_en_M0, 1);
      chk("t6_lenerr", len_err, 0);
      cyc();
      S0_RVALID = 0; S0_RLAST = 0;
      #1 chk("t6_free", data_en_M0, 0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
